// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - timing presets, total helper and decode record for video_timing_generator
package video_timing_pkg;

  localparam int VTG_MAX_W = 16;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_HSYNC_POL = 0;
  localparam int VGA_VSYNC_POL = 0;

  // 800x600@60, 40 MHz pixel clock
  localparam int SVGA_H_ACTIVE  = 800;
  localparam int SVGA_H_FRONT   = 40;
  localparam int SVGA_H_SYNC    = 128;
  localparam int SVGA_H_BACK    = 88;
  localparam int SVGA_V_ACTIVE  = 600;
  localparam int SVGA_V_FRONT   = 1;
  localparam int SVGA_V_SYNC    = 4;
  localparam int SVGA_V_BACK    = 23;
  localparam int SVGA_HSYNC_POL = 1;
  localparam int SVGA_VSYNC_POL = 1;

  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

  typedef struct packed {
    logic                 hsync;
    logic                 vsync;
    logic                 active;
    logic [VTG_MAX_W-1:0] x;
    logic [VTG_MAX_W-1:0] y;
    logic                 line_start;
    logic                 frame_start;
  } vtg_decode_t;

endpackage

// File: rtl/video_timing_axis.sv
// rtl/video_timing_axis.sv - one timing axis: wrapping counter with sync, active and origin decode
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48,
  parameter int POL    = 0,
  parameter int WIDTH  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_restart,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_sync,
  output logic             o_active,
  output logic             o_zero
);

  localparam int TOTAL = timing_total(ACTIVE, FRONT, SYNC, BACK);

  generate
    if (ACTIVE <= 0 || FRONT <= 0 || SYNC <= 0 || BACK <= 0) begin : g_bad_length
      $error("video_timing_axis: active, porch and sync lengths must be non-zero");
    end
    if (WIDTH < 1 || WIDTH > VTG_MAX_W || (TOTAL - 1) >= (1 << WIDTH)) begin : g_bad_width
      $error("video_timing_axis: WIDTH cannot hold TOTAL-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LAST      = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] ACT_END   = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] SYNC_BEG  = WIDTH'(ACTIVE + FRONT);
  localparam logic [WIDTH-1:0] SYNC_END  = WIDTH'(ACTIVE + FRONT + SYNC);
  localparam logic             ASSERTED  = (POL != 0);

  logic [WIDTH-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = (r_count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_restart) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_wrap   = w_wrap;
  assign o_sync   = ((r_count >= SYNC_BEG) && (r_count < SYNC_END)) ? ASSERTED : ~ASSERTED;
  assign o_active = (r_count < ACT_END);
  assign o_zero   = (r_count == '0);

endmodule

// File: rtl/video_timing_generator.sv
// rtl/video_timing_generator.sv - parametrised VGA/DVI timing generator; VTG_LOOKAHEAD_EN adds a lookahead fetch port
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int HSYNC_POL = VGA_HSYNC_POL,
  parameter int VSYNC_POL = VGA_VSYNC_POL,
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10,
  parameter int LOOKAHEAD = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_en,
  input  logic               restart,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               line_start,
  output logic               frame_start
`ifdef VTG_LOOKAHEAD_EN
  ,
  output logic [X_WIDTH-1:0] fetch_x,
  output logic [Y_WIDTH-1:0] fetch_y,
  output logic               fetch_active
`endif
);

  logic [X_WIDTH-1:0] w_h_count;
  logic [Y_WIDTH-1:0] w_v_count;
  logic               w_h_wrap;
  logic               w_v_en;
  logic               w_unused_v_wrap;
  logic               w_hsync;
  logic               w_vsync;
  logic               w_h_act;
  logic               w_v_act;
  logic               w_h_zero;
  logic               w_v_zero;

  assign w_v_en = pix_en && w_h_wrap;

  video_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (HSYNC_POL),
    .WIDTH  (X_WIDTH)
  ) u_h_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (pix_en),
    .i_restart (restart),
    .o_count   (w_h_count),
    .o_wrap    (w_h_wrap),
    .o_sync    (w_hsync),
    .o_active  (w_h_act),
    .o_zero    (w_h_zero)
  );

  video_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (VSYNC_POL),
    .WIDTH  (Y_WIDTH)
  ) u_v_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (w_v_en),
    .i_restart (restart),
    .o_count   (w_v_count),
    .o_wrap    (w_unused_v_wrap),
    .o_sync    (w_vsync),
    .o_active  (w_v_act),
    .o_zero    (w_v_zero)
  );

`ifdef VTG_LOOKAHEAD_EN
  generate
    if (LOOKAHEAD < 1 || LOOKAHEAD > 8) begin : g_bad_lookahead
      $error("video_timing_generator: LOOKAHEAD must be 1..8");
    end
  endgenerate

  localparam logic H_ASSERTED = (HSYNC_POL != 0);
  localparam logic V_ASSERTED = (VSYNC_POL != 0);
  localparam vtg_decode_t DEC_ORIGIN = '{
    hsync: ~H_ASSERTED, vsync: ~V_ASSERTED, active: 1'b1,
    x: '0, y: '0, line_start: 1'b1, frame_start: 1'b1
  };

  vtg_decode_t w_dec;
  vtg_decode_t r_pipe [LOOKAHEAD];

  assign w_dec = '{
    hsync:       w_hsync,
    vsync:       w_vsync,
    active:      w_h_act && w_v_act,
    x:           VTG_MAX_W'(w_h_count),
    y:           VTG_MAX_W'(w_v_count),
    line_start:  w_h_zero,
    frame_start: w_h_zero && w_v_zero
  };

  // Counters lead the display by LOOKAHEAD ticks; the pipe re-aligns them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LOOKAHEAD; i++) r_pipe[i] <= DEC_ORIGIN;
    end else if (restart) begin
      for (int i = 0; i < LOOKAHEAD; i++) r_pipe[i] <= DEC_ORIGIN;
    end else if (pix_en) begin
      r_pipe[0] <= w_dec;
      for (int i = 1; i < LOOKAHEAD; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign hsync        = r_pipe[LOOKAHEAD-1].hsync;
  assign vsync        = r_pipe[LOOKAHEAD-1].vsync;
  assign active       = r_pipe[LOOKAHEAD-1].active;
  assign x            = r_pipe[LOOKAHEAD-1].x[X_WIDTH-1:0];
  assign y            = r_pipe[LOOKAHEAD-1].y[Y_WIDTH-1:0];
  assign line_start   = r_pipe[LOOKAHEAD-1].line_start;
  assign frame_start  = r_pipe[LOOKAHEAD-1].frame_start;
  assign fetch_x      = w_h_count;
  assign fetch_y      = w_v_count;
  assign fetch_active = w_h_act && w_v_act;
`else
  localparam int UNUSED_LOOKAHEAD = LOOKAHEAD;

  assign hsync       = w_hsync;
  assign vsync       = w_vsync;
  assign active      = w_h_act && w_v_act;
  assign x           = w_h_count;
  assign y           = w_v_count;
  assign line_start  = w_h_zero;
  assign frame_start = w_h_zero && w_v_zero;
`endif

endmodule
